// File: rtl/sdram_line_prefetcher.sv
// rtl/sdram_line_prefetcher.sv - burst-read line prefetcher feeding a first-word-fall-through pixel FIFO
`timescale 1ns/1ps
module sdram_line_prefetcher #(
  parameter int WordLength   = 16,
  parameter int AddressWidth = 24,
  parameter int BurstLength  = 8,
  parameter int LineBursts   = 80,
  parameter int FifoDepth    = 32
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    i_line_start,
  input  logic [AddressWidth-1:0] i_line_base,
  output logic                    o_sdram_enable,
  output logic                    o_sdram_rw,
  output logic [AddressWidth-1:0] o_sdram_addr,
  input  logic                    i_sdram_busy,
  input  logic                    i_sdram_valid_rd,
  input  logic [WordLength-1:0]   i_sdram_data,
  output logic [WordLength-1:0]   o_pix_data,
  output logic                    o_pix_valid,
  input  logic                    i_pix_ready,
  output logic                    o_fetch_done,
  output logic                    o_underflow,
  output logic                    o_busy
);
  localparam int WcW  = $clog2(BurstLength) + 1;
  localparam int BcW  = $clog2(LineBursts) + 1;
  localparam int CntW = $clog2(FifoDepth) + 1;
  localparam int PtrW = $clog2(FifoDepth);
  localparam logic [WcW-1:0]          WordsPerBurst = WcW'(BurstLength);
  localparam logic [BcW-1:0]          BurstsPerLine = BcW'(LineBursts);
  localparam logic [CntW-1:0]         Depth         = CntW'(FifoDepth);
  localparam logic [CntW-1:0]         Room          = CntW'(BurstLength);
  localparam logic [AddressWidth-1:0] AddrStep      = AddressWidth'(BurstLength);

  typedef enum logic [2:0] {IDLE, WAIT_ROOM, ISSUE, RECEIVE, DRAIN} state_e;

  state_e                  state_q, state_d;
  logic [AddressWidth-1:0] addr_q, addr_d;
  logic [BcW-1:0]          burst_q, burst_d;
  logic [WcW-1:0]          word_q, word_d;
  logic                    fetch_done_q, fetch_done_d;
  logic                    underflow_q, underflow_d;
  logic [WordLength-1:0]   mem_q [FifoDepth];
  logic [PtrW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]         count_q;
  logic                    push, push_ok, pop, flush, last_word;

  assign o_sdram_rw     = 1'b1;
  assign o_sdram_addr   = addr_q;
  assign o_sdram_enable = (state_q == ISSUE) && !i_sdram_busy;
  assign o_pix_valid    = (count_q != '0);
  assign o_pix_data     = o_pix_valid ? mem_q[rd_ptr_q] : '0;
  assign o_fetch_done   = fetch_done_q;
  assign o_underflow    = underflow_q;
  assign o_busy         = (state_q != IDLE);

  assign pop       = o_pix_valid && i_pix_ready && !flush;
  assign push_ok   = push && (count_q != Depth);
  assign last_word = i_sdram_valid_rd && (word_q == WcW'(1));

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    burst_d      = burst_q;
    word_d       = word_q;
    fetch_done_d = 1'b0;
    underflow_d  = underflow_q;
    push         = 1'b0;
    flush        = 1'b0;
    if (i_pix_ready && !o_pix_valid && (state_q != IDLE)) underflow_d = 1'b1;
    case (state_q)
      IDLE: ;
      WAIT_ROOM: if ((Depth - count_q) >= Room) state_d = ISSUE;
      ISSUE: if (o_sdram_enable) begin
        state_d = RECEIVE;
        word_d  = WordsPerBurst;
      end
      RECEIVE: if (i_sdram_valid_rd) begin
        push   = 1'b1;
        word_d = word_q - WcW'(1);
        if (last_word) begin
          addr_d  = addr_q + AddrStep;
          burst_d = burst_q + BcW'(1);
          if (burst_q + BcW'(1) == BurstsPerLine) begin
            state_d      = IDLE;
            fetch_done_d = 1'b1;
          end else begin
            state_d = WAIT_ROOM;
          end
        end
      end
      DRAIN: if (i_sdram_valid_rd) begin
        word_d = word_q - WcW'(1);
        if (last_word) state_d = ISSUE;
      end
      default: state_d = IDLE;
    endcase
    // A restart while a burst is outstanding must swallow that burst's remaining words.
    if (i_line_start) begin
      addr_d = i_line_base;
      if (state_q != DRAIN) begin
        flush        = 1'b1;
        push         = 1'b0;
        underflow_d  = 1'b0;
        burst_d      = '0;
        fetch_done_d = 1'b0;
        if (state_q == RECEIVE && !last_word) begin
          state_d = DRAIN;
          word_d  = word_q - WcW'(i_sdram_valid_rd);
        end else if (state_q == ISSUE && o_sdram_enable) begin
          state_d = DRAIN;
          word_d  = WordsPerBurst;
        end else begin
          state_d = ISSUE;
        end
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      burst_q      <= '0;
      word_q       <= '0;
      fetch_done_q <= 1'b0;
      underflow_q  <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      burst_q      <= burst_d;
      word_q       <= word_d;
      fetch_done_q <= fetch_done_d;
      underflow_q  <= underflow_d;
      if (flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
        if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
        count_q <= count_q + CntW'(push_ok) - CntW'(pop);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (push_ok) mem_q[wr_ptr_q] <= i_sdram_data;
  end
endmodule

// File: tb/tb_sdram_line_prefetcher.sv
// tb/tb_sdram_line_prefetcher.sv - scoreboard bench for sdram_line_prefetcher with a burst-read controller model
`timescale 1ns/1ps
module tb_sdram_line_prefetcher;
  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        i_line_start = 1'b0;
  logic [23:0] i_line_base = '0;
  logic        o_sdram_enable, o_sdram_rw;
  logic [23:0] o_sdram_addr;
  logic        i_sdram_busy = 1'b0;
  logic        i_sdram_valid_rd;
  logic [15:0] i_sdram_data;
  logic [15:0] o_pix_data;
  logic        o_pix_valid;
  logic        i_pix_ready = 1'b0;
  logic        o_fetch_done, o_underflow, o_busy;

  sdram_line_prefetcher #(
    .WordLength(16), .AddressWidth(24), .BurstLength(8), .LineBursts(8), .FifoDepth(32)
  ) dut (
    .CLK(CLK), .RST(RST),
    .i_line_start(i_line_start), .i_line_base(i_line_base),
    .o_sdram_enable(o_sdram_enable), .o_sdram_rw(o_sdram_rw), .o_sdram_addr(o_sdram_addr),
    .i_sdram_busy(i_sdram_busy), .i_sdram_valid_rd(i_sdram_valid_rd), .i_sdram_data(i_sdram_data),
    .o_pix_data(o_pix_data), .o_pix_valid(o_pix_valid), .i_pix_ready(i_pix_ready),
    .o_fetch_done(o_fetch_done), .o_underflow(o_underflow), .o_busy(o_busy)
  );

  always #5 CLK = ~CLK;

  int tests = 0;
  int fails = 0;
  logic [15:0] exp_q[$];
  logic [23:0] exp_addr_q[$];
  logic [15:0] pend_q[$];
  int   words_left = 0;
  int   widx = 0;
  int   words_driven = 0;
  int   en_cnt = 0;
  int   fd_cnt = 0;
  bit   gap_en = 1'b0;
  bit   tog = 1'b0;
  logic [15:0] cur_base = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Pixel scoreboard: a flush on line start beats a same-cycle pop.
  always @(negedge CLK) begin
    if (!RST && o_pix_valid && i_pix_ready && !i_line_start) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL pix_extra: got 0x%0h with no word expected", o_pix_data);
      end else begin
        check("pix_data", 32'(o_pix_data), 32'(exp_q.pop_front()));
      end
    end
    if (o_fetch_done) fd_cnt++;
  end

  // Controller request side: every enable must match the next expected burst address.
  always @(negedge CLK) begin
    if (o_sdram_enable) begin
      en_cnt++;
      check("enable_overlap", 32'(words_left + pend_q.size()), 32'd0);
      if (exp_addr_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL enable_extra: addr 0x%0h with no burst expected", o_sdram_addr);
      end else begin
        check("burst_addr", 32'(o_sdram_addr), 32'(exp_addr_q.pop_front()));
      end
      pend_q.push_back(o_sdram_addr[15:0]);
    end
  end

  // Controller return side: data word = low address bits + offset, optional one-cycle gaps.
  initial begin : ctrl_drv
    i_sdram_valid_rd = 1'b0;
    i_sdram_data = '0;
    forever begin
      @(posedge CLK); #1;
      i_sdram_valid_rd = 1'b0;
      tog = !tog;
      if (words_left == 0 && pend_q.size() > 0) begin
        cur_base = pend_q.pop_front();
        widx = 0;
        words_left = 8;
      end
      if (words_left > 0 && !(gap_en && tog)) begin
        i_sdram_valid_rd = 1'b1;
        i_sdram_data = cur_base + 16'(widx);
        widx++;
        words_left--;
        words_driven++;
      end
    end
  end

  task automatic start_line(input logic [23:0] base);
    i_line_start = 1'b1;
    i_line_base = base;
    exp_q.delete();
    exp_addr_q.delete();
    for (int b = 0; b < 8; b++) exp_addr_q.push_back(base + 24'(b * 8));
    for (int w = 0; w < 64; w++) exp_q.push_back(base[15:0] + 16'(w));
    words_driven = 0;
    @(posedge CLK); #1;
    i_line_start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || o_busy) && n < 3000) begin
      @(negedge CLK);
      n++;
    end
    check({name, "_complete"}, 32'(n < 3000), 32'd1);
    check({name, "_bursts_left"}, 32'(exp_addr_q.size()), 32'd0);
    @(posedge CLK); #1;
  endtask

  task automatic wait_words(input int target);
    int n = 0;
    while (words_driven < target && n < 200) begin
      @(negedge CLK);
      n++;
    end
    check("wait_words", 32'(n < 200), 32'd1);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, tests %0d", tests);
    $fatal(1);
  end

  initial begin : main
    int bad;
    int en0;
    repeat (3) @(negedge CLK);
    check("rst_enable", 32'(o_sdram_enable), 32'd0);
    check("rst_addr", 32'(o_sdram_addr), 32'd0);
    check("rst_pix_valid", 32'(o_pix_valid), 32'd0);
    check("rst_pix_data", 32'(o_pix_data), 32'd0);
    check("rst_fetch_done", 32'(o_fetch_done), 32'd0);
    check("rst_underflow", 32'(o_underflow), 32'd0);
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rw_tied", 32'(o_sdram_rw), 32'd1);
    RST = 1'b0;
    @(posedge CLK); #1;

    // Basic line at 0x000100, consumer always ready so the empty FIFO underflows first.
    i_pix_ready = 1'b1;
    start_line(24'h000100);
    @(negedge CLK);
    check("basic_first_enable", 32'(o_sdram_enable), 32'd1);
    check("basic_busy", 32'(o_busy), 32'd1);
    @(posedge CLK); #1;
    wait_idle("basic");
    check("basic_fetch_done", 32'(fd_cnt), 32'd1);
    check("basic_busy_after", 32'(o_busy), 32'd0);
    check("basic_underflow", 32'(o_underflow), 32'd1);

    i_pix_ready = 1'b0;
    repeat (5) @(posedge CLK);
    #1;
    check("underflow_sticky", 32'(o_underflow), 32'd1);

    // Backpressure: only four bursts fit a 32-word FIFO.
    en0 = en_cnt;
    start_line(24'h010040);
    @(negedge CLK);
    check("underflow_cleared", 32'(o_underflow), 32'd0);
    repeat (200) @(negedge CLK);
    check("bp_bursts_issued", 32'(en_cnt - en0), 32'd4);
    check("bp_bursts_pending", 32'(exp_addr_q.size()), 32'd4);
    check("bp_head_word", 32'(o_pix_data), 32'h0040);
    check("bp_busy", 32'(o_busy), 32'd1);
    check("bp_no_underflow", 32'(o_underflow), 32'd0);
    @(posedge CLK); #1;
    i_pix_ready = 1'b1;
    gap_en = 1'b1;
    wait_idle("backpressure");
    gap_en = 1'b0;
    check("bp_bursts_total", 32'(en_cnt - en0), 32'd8);
    check("bp_fetch_done", 32'(fd_cnt), 32'd2);

    // Busy stall: enable must wait out 50 busy cycles with the address held.
    i_sdram_busy = 1'b1;
    start_line(24'h000200);
    bad = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge CLK);
      if (o_sdram_enable !== 1'b0 || o_sdram_addr !== 24'h000200) bad++;
    end
    check("stall_enable_low_addr_held", 32'(bad), 32'd0);
    @(posedge CLK); #1;
    i_sdram_busy = 1'b0;
    @(negedge CLK);
    check("stall_enable_on_release", 32'(o_sdram_enable), 32'd1);
    check("stall_addr", 32'(o_sdram_addr), 32'h000200);
    @(posedge CLK); #1;
    wait_idle("stall");
    check("stall_fetch_done", 32'(fd_cnt), 32'd3);

    // Restart after three words of the first burst; remaining five are discarded.
    i_pix_ready = 1'b0;
    start_line(24'h001000);
    wait_words(3);
    @(posedge CLK); #1;
    start_line(24'h002000);
    @(negedge CLK);
    check("restart_fifo_empty", 32'(o_pix_valid), 32'd0);
    check("restart_busy", 32'(o_busy), 32'd1);
    check("restart_no_enable_yet", 32'(o_sdram_enable), 32'd0);
    @(posedge CLK); #1;
    i_pix_ready = 1'b1;
    wait_idle("restart");
    check("restart_fetch_done", 32'(fd_cnt), 32'd4);

    // Asynchronous reset in the middle of a burst.
    i_pix_ready = 1'b0;
    start_line(24'h003000);
    wait_words(3);
    check("arst_pre_valid", 32'(o_pix_valid), 32'd1);
    check("arst_pre_addr", 32'(o_sdram_addr), 32'h003000);
    #2;
    RST = 1'b1;
    #1;
    check("arst_busy", 32'(o_busy), 32'd0);
    check("arst_pix_valid", 32'(o_pix_valid), 32'd0);
    check("arst_addr", 32'(o_sdram_addr), 32'd0);
    check("arst_enable", 32'(o_sdram_enable), 32'd0);
    exp_q.delete();
    exp_addr_q.delete();
    @(negedge CLK);
    RST = 1'b0;
    repeat (10) @(negedge CLK);
    check("arst_ignore_valid", 32'(o_pix_valid), 32'd0);
    check("arst_ignore_busy", 32'(o_busy), 32'd0);
    check("arst_fetch_done", 32'(fd_cnt), 32'd4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/sdram_line_prefetcher.md
# sdram_line_prefetcher

Read-side client of the SDRAM controller for the VGA path. On a line-start request it issues consecutive 8-word burst reads starting at a line base address and captures the returned words into an internal FIFO. The pixel pipeline pops the FIFO one word per accepted cycle. It sits between the SDRAM controller (read handshake) and the VGA pixel serializer.

## Interface
- WordLength, 16, data word width
- AddressWidth, 24, SDRAM word address width ({bank, row, col})
- BurstLength, 8, words per controller burst; must match controller mode register
- LineBursts, 80, bursts per line (80 × 8 = 640 pixels)
- FifoDepth, 32, pixel FIFO depth in words; power of two, ≥ 2×BurstLength
- CLK  in  1  single clock; all logic on rising edge
- RST  in  1  asynchronous, active-high reset
- i_line_start  in  1  one-cycle pulse: begin fetching a new line
- i_line_base  in  AddressWidth  first word address of the line; sampled with i_line_start
- o_sdram_enable  out  1  request strobe to controller
- o_sdram_rw  out  1  tied 1 (read)
- o_sdram_addr  out  AddressWidth  burst start address
- i_sdram_busy  in  1  controller busy
- i_sdram_valid_rd  in  1  controller read word valid this cycle
- i_sdram_data  in  WordLength  controller read data
- o_pix_data  out  WordLength  FIFO head word
- o_pix_valid  out  1  FIFO non-empty
- i_pix_ready  in  1  consumer accepts head word
- o_fetch_done  out  1  one-cycle pulse after last burst of a line is fully captured
- o_underflow  out  1  sticky: i_pix_ready seen while FIFO empty and line active
- o_busy  out  1  state ≠ IDLE

## Operation
- States: IDLE, WAIT_ROOM, ISSUE, RECEIVE, DRAIN.
- IDLE: on i_line_start → flush FIFO, load address register = i_line_base, burst counter = 0, clear o_underflow; go ISSUE.
- WAIT_ROOM: go ISSUE when free FIFO slots (FifoDepth − count) ≥ BurstLength.
- ISSUE: o_sdram_enable = !i_sdram_busy (combinational); o_sdram_addr = address register, held stable throughout ISSUE. Cycle with enable high → RECEIVE, word counter = BurstLength.
- RECEIVE: each cycle with i_sdram_valid_rd writes i_sdram_data into FIFO and decrements word counter. On the last word: address += BurstLength (modulo 2^AddressWidth), burst counter += 1; if burst counter reaches LineBursts → IDLE with o_fetch_done pulse, else → WAIT_ROOM.
- i_line_start while not IDLE (abort/restart): FIFO flushed, new base/counters loaded, o_underflow cleared. In WAIT_ROOM/ISSUE (no burst in flight) → ISSUE directly. In RECEIVE → DRAIN: remaining words of the in-flight burst are counted and discarded (not written), then → ISSUE. A further i_line_start in DRAIN reloads base only; drain continues.
- FIFO: first-word-fall-through; pop when o_pix_valid && i_pix_ready. Simultaneous push and pop leaves count unchanged. Room check guarantees no overflow; a push when full is dropped (must never occur).
- o_underflow sets when i_pix_ready && !o_pix_valid && state ≠ IDLE.
- o_sdram_rw constant 1.

## Timing
- Reset values: state IDLE, o_sdram_enable 0, o_sdram_addr 0, FIFO empty, o_pix_valid 0, o_pix_data don't-care (model 0), o_fetch_done 0, o_underflow 0, o_busy 0.
- i_line_start at cycle N → ISSUE at N+1; o_sdram_enable first possible at N+1 (if busy low).
- o_sdram_enable is high for exactly one cycle per burst. Refresh-induced busy only stretches ISSUE.
- Words are pushed the same cycle i_sdram_valid_rd is high. They are visible on o_pix_data the next cycle.
- Valid words need not be contiguous; counting is per valid cycle.
- o_fetch_done is registered, high for the cycle after the last push.
- Counters: word counter $clog2(BurstLength)+1 bits; burst counter $clog2(LineBursts)+1 bits; FIFO count $clog2(FifoDepth)+1 bits.

## Test plan
- Basic line: LineBursts=2, base 0x000100, controller model returns 0x0100..0x010F → two enables with addr 0x000100, 0x000108; pixel side reads 16 words in order; o_fetch_done one pulse; o_busy low after.
- Backpressure: i_pix_ready held 0, LineBursts=8, FifoDepth=32 → exactly 4 bursts issued, then WAIT_ROOM. Release ready → remaining 4 bursts issued; all 64 words delivered in order.
- Busy stall: i_sdram_busy high for 50 cycles during ISSUE → o_sdram_enable 0 throughout, asserts the cycle busy drops; o_sdram_addr stable.
- Restart mid-burst: i_line_start with base 0x002000 after 3 of 8 words → 5 words discarded, FIFO empty, next enable addr 0x002000, only new-line data delivered.
- Underflow: i_pix_ready high with empty FIFO after line start → o_underflow 1 and stays 1 until next i_line_start.
- Async reset: RST asserted mid-RECEIVE → outputs immediately at reset values without waiting for a clock edge; subsequent valid_rd words are ignored.
